ws2811_rx: RTL and testbench



---
 rtl/ws2811_rx.sv | 127 ++++++++++++
 tb/tb_ws2811_rx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ws2811_rx.sv
// ws2811_rx: WS2811/WS2812 NRZ bitstream decoder producing indexed 24-bit pixels.
// Ports:
//    clk, reset           system clock, synchronous active-high reset
//    din                  asynchronous LED data line
//    red, green, blue     colour of the last decoded pixel
//    address              index of that pixel within the current frame
//    pixel_valid          one-cycle strobe when a pixel is emitted
//    frame_done           one-cycle strobe on a latch gap after >=1 pixel
//    bit_error            one-cycle strobe on glitch, overlong high or truncated pixel
module ws2811_rx #(
   parameter int ADDR_W        = 8,
   parameter int MIN_HIGH      = 4,
   parameter int BIT_THRESHOLD = 26,
   parameter int MAX_HIGH      = 100,
   parameter int RESET_CYCLES  = 2500
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              din,
   output logic [7:0]        red,
   output logic [7:0]        green,
   output logic [7:0]        blue,
   output logic [ADDR_W-1:0] address,
   output logic              pixel_valid,
   output logic              frame_done,
   output logic              bit_error
);
   localparam int LW = $clog2(RESET_CYCLES + 1);
   localparam int HW = $clog2(MAX_HIGH + 2);
   typedef enum logic [1:0] {SYNC, IDLE, HIGH} state_t;
   state_t            state;
   logic              d1, din_s;
   logic [LW-1:0]     lcnt;
   logic [HW-1:0]     hcnt;
   logic [23:0]       sr;
   logic [4:0]        bcnt;
   logic [ADDR_W-1:0] idx;
   logic              got_pix;
   logic              bit_v;
   logic [23:0]       px;
   assign bit_v = hcnt >= HW'(BIT_THRESHOLD);
   assign px    = {sr[22:0], bit_v};
   always_ff @(posedge clk) begin
      if (reset) begin
         d1          <= 1'b0;
         din_s       <= 1'b0;
         state       <= SYNC;
         lcnt        <= '0;
         hcnt        <= '0;
         sr          <= '0;
         bcnt        <= '0;
         idx         <= '0;
         got_pix     <= 1'b0;
         red         <= '0;
         green       <= '0;
         blue        <= '0;
         address     <= '0;
         pixel_valid <= 1'b0;
         frame_done  <= 1'b0;
         bit_error   <= 1'b0;
      end else begin
         d1          <= din;
         din_s       <= d1;
         pixel_valid <= 1'b0;
         frame_done  <= 1'b0;
         bit_error   <= 1'b0;
         case (state)
            // Leaving SYNC parks the low counter at its saturation value so
            // the gap that got us here never fires a latch strobe.
            SYNC: begin
               if (din_s) lcnt <= '0;
               else if (lcnt == LW'(RESET_CYCLES - 1)) begin
                  lcnt    <= LW'(RESET_CYCLES);
                  state   <= IDLE;
                  bcnt    <= '0;
                  idx     <= '0;
                  got_pix <= 1'b0;
               end else lcnt <= lcnt + LW'(1);
            end
            // IDLE doubles as LOW; a saturated low counter means the latch
            // for this gap has already been handled.
            IDLE: begin
               if (din_s) begin
                  hcnt  <= HW'(1);
                  state <= HIGH;
               end else if (lcnt == LW'(RESET_CYCLES - 1)) begin
                  lcnt       <= LW'(RESET_CYCLES);
                  frame_done <= got_pix;
                  bit_error  <= bcnt != 5'd0;
                  bcnt       <= '0;
                  idx        <= '0;
                  got_pix    <= 1'b0;
               end else if (lcnt != LW'(RESET_CYCLES)) lcnt <= lcnt + LW'(1);
            end
            HIGH: begin
               if (din_s) begin
                  // Current cycle is high number MAX_HIGH+1: stuck line.
                  if (hcnt == HW'(MAX_HIGH)) begin
                     bit_error <= 1'b1;
                     bcnt      <= '0;
                     lcnt      <= '0;
                     state     <= SYNC;
                  end else hcnt <= hcnt + HW'(1);
               end else begin
                  state <= IDLE;
                  lcnt  <= LW'(1);
                  if (hcnt < HW'(MIN_HIGH)) bit_error <= 1'b1;
                  else begin
                     sr <= px;
                     if (bcnt == 5'd23) begin
                        green       <= px[23:16];
                        red         <= px[15:8];
                        blue        <= px[7:0];
                        address     <= idx;
                        pixel_valid <= 1'b1;
                        idx         <= idx + ADDR_W'(1);
                        got_pix     <= 1'b1;
                        bcnt        <= '0;
                     end else bcnt <= bcnt + 5'd1;
                  end
               end
            end
            default: state <= SYNC;
         endcase
      end
   end
endmodule

// File: tb/tb_ws2811_rx.sv
// tb_ws2811_rx: randomized and directed bench for ws2811_rx against a run-length pixel model.
module tb_ws2811_rx;
   localparam int RC = 2500;
   logic       clk = 1'b0, reset = 1'b1, din = 1'b0;
   logic [7:0] red, green, blue, address;
   logic       pixel_valid, frame_done, bit_error;
   int         tests = 0, fails = 0;
   bit         m_d1, m_ds, m_ready, m_high, m_got;
   int         m_lo, m_hi, m_idx;
   bit         m_bits[$];
   logic [7:0] e_r, e_g, e_b, e_a;
   bit         e_pv, e_fd, e_be;
   logic [31:0] cap[$];
   logic [31:0] exp_q[$];
   int         n_fd, n_be;

   always #5 clk = ~clk;

   ws2811_rx dut (
      .clk(clk), .reset(reset), .din(din),
      .red(red), .green(green), .blue(blue), .address(address),
      .pixel_valid(pixel_valid), .frame_done(frame_done), .bit_error(bit_error)
   );

   // Model: track low/high run lengths of the synchronized line and a bit list.
   task automatic model_step();
      bit x;
      logic [23:0] p;
      e_pv = 0; e_fd = 0; e_be = 0;
      if (reset) begin
         m_d1 = 0; m_ds = 0; m_ready = 0; m_high = 0; m_got = 0;
         m_lo = 0; m_hi = 0; m_idx = 0; m_bits.delete();
         {e_r, e_g, e_b, e_a} = '0;
         return;
      end
      x = m_ds; m_ds = m_d1; m_d1 = din;
      if (!m_ready) begin
         m_lo = x ? 0 : m_lo + 1;
         if (m_lo == RC) begin m_ready = 1; m_idx = 0; m_got = 0; m_bits.delete(); end
      end else if (m_high) begin
         if (x) begin
            m_hi++;
            if (m_hi > 100) begin e_be = 1; m_bits.delete(); m_ready = 0; m_high = 0; m_lo = 0; end
         end else begin
            m_high = 0; m_lo = 1;
            if (m_hi < 4) e_be = 1;
            else begin
               m_bits.push_back(m_hi >= 26);
               if (m_bits.size() == 24) begin
                  p = '0;
                  foreach (m_bits[i]) p = {p[22:0], m_bits[i]};
                  {e_g, e_r, e_b} = p;
                  e_a = 8'(m_idx);
                  m_idx = (m_idx + 1) % 256;
                  e_pv = 1; m_got = 1; m_bits.delete();
               end
            end
         end
      end else if (x) begin
         m_high = 1; m_hi = 1;
      end else if (m_lo < RC) begin
         m_lo++;
         if (m_lo == RC) begin
            e_fd = m_got; e_be = m_bits.size() != 0;
            m_bits.delete(); m_idx = 0; m_got = 0;
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      model_step();
      tests++;
      if ({red, green, blue, address, pixel_valid, frame_done, bit_error} !==
          {e_r, e_g, e_b, e_a, e_pv, e_fd, e_be}) begin
         fails++;
         $display("FAIL cycle t=%0t got rgb=%h%h%h a=%0d pv=%b fd=%b be=%b want rgb=%h%h%h a=%0d pv=%b fd=%b be=%b",
                  $time, red, green, blue, address, pixel_valid, frame_done, bit_error,
                  e_r, e_g, e_b, e_a, e_pv, e_fd, e_be);
      end
      if (pixel_valid) cap.push_back({address, green, red, blue});
      n_fd += int'(frame_done);
      n_be += int'(bit_error);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s got %h want %h", name, act, want);
      end
   endtask

   task automatic hold(input bit v, input int n);
      din = v;
      repeat (n) tick();
   endtask

   task automatic pulse(input int h, input int per);
      hold(1'b1, h);
      hold(1'b0, per - h);
   endtask

   task automatic send_bit(input bit b);
      pulse(b ? 35 : 17, 62);
   endtask

   task automatic send_px(input logic [23:0] p);
      for (int i = 23; i >= 0; i--) send_bit(p[i]);
   endtask

   task automatic rand_px(input logic [23:0] p);
      int h;
      for (int i = 23; i >= 0; i--) begin
         h = p[i] ? int'($urandom_range(26, 60)) : int'($urandom_range(4, 25));
         pulse(h, h + int'($urandom_range(4, 30)));
      end
   endtask

   task automatic clear();
      cap.delete(); n_fd = 0; n_be = 0;
   endtask

   initial begin
      logic [23:0] p;
      int n;
      clear();
      hold(1'b0, 3);
      chk("reset_outputs", {red, green, blue, address}, 32'h0);
      chk("reset_strobes", {29'h0, pixel_valid, frame_done, bit_error}, 32'h0);
      reset = 1'b0;

      // Startup: bits before the first full gap are ignored.
      for (int i = 0; i < 10; i++) send_bit(1'(i));
      hold(1'b0, 2500);
      send_px(24'h123456);
      hold(1'b0, 3000);
      chk("sync_count", cap.size(), 1);
      chk("sync_pixel", cap[0], 32'h00123456);
      chk("sync_red", red, 8'h34);
      chk("sync_fd", n_fd, 1);
      chk("sync_be", n_be, 0);

      // Two-pixel frame, then a second frame restarting at address 0.
      clear();
      send_px(24'hFF0000);
      send_px(24'h0000FF);
      hold(1'b0, 3000);
      send_px(24'hFF0000);
      hold(1'b0, 3000);
      chk("two_count", cap.size(), 3);
      chk("two_px0", cap[0], 32'h00FF0000);
      chk("two_px1", cap[1], 32'h010000FF);
      chk("two_px2", cap[2], 32'h00FF0000);
      chk("two_fd", n_fd, 2);

      // Threshold 26/25 and a width-3 glitch inside one pixel.
      clear();
      p = 24'hA5C3F0;
      pulse(26, 62);
      pulse(3, 62);
      pulse(25, 62);
      for (int i = 21; i >= 0; i--) send_bit(p[i]);
      hold(1'b0, 3000);
      chk("thr_count", cap.size(), 1);
      chk("thr_pixel", cap[0], 32'h00A5C3F0);
      chk("thr_be", n_be, 1);
      chk("thr_fd", n_fd, 1);

      // Overlong high mid-pixel; following bits ignored until a full gap.
      clear();
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      hold(1'b1, 150);
      for (int i = 0; i < 3; i++) send_bit(1'b0);
      chk("long_be", n_be, 1);
      chk("long_nopx", cap.size(), 0);
      hold(1'b0, 2600);
      send_px(24'h0F0F0F);
      hold(1'b0, 3000);
      chk("long_pixel", cap[0], 32'h000F0F0F);
      chk("long_fd", n_fd, 1);

      // Truncated pixel, alone and after a full pixel.
      clear();
      for (int i = 0; i < 12; i++) send_bit(1'(i));
      hold(1'b0, 3000);
      chk("trunc_be", n_be, 1);
      chk("trunc_fd", n_fd, 0);
      chk("trunc_nopx", cap.size(), 0);
      clear();
      send_px(24'h00FF00);
      for (int i = 0; i < 12; i++) send_bit(1'(i));
      hold(1'b0, 3000);
      chk("trunc2_be", n_be, 1);
      chk("trunc2_fd", n_fd, 1);
      chk("trunc2_count", cap.size(), 1);

      // Reset in the middle of a pixel.
      clear();
      for (int i = 0; i < 10; i++) send_bit(1'b1);
      din = 1'b0;
      reset = 1'b1;
      tick();
      chk("mid_rst_out", {red, green, blue, address}, 32'h0);
      reset = 1'b0;
      hold(1'b0, 2600);
      send_px(24'hABCDEF);
      hold(1'b0, 3000);
      chk("mid_rst_pixel", cap[0], 32'h00ABCDEF);
      chk("mid_rst_fd", n_fd, 1);

      // Random frames with random pulse widths and gaps.
      clear();
      exp_q.delete();
      for (int f = 0; f < 2; f++) begin
         n = int'($urandom_range(1, 3));
         for (int k = 0; k < n; k++) begin
            p = 24'($urandom);
            exp_q.push_back({8'(k), p});
            rand_px(p);
         end
         hold(1'b0, int'($urandom_range(2600, 3000)));
      end
      chk("rand_count", cap.size(), exp_q.size());
      foreach (exp_q[i]) chk("rand_pixel", cap[i], exp_q[i]);
      chk("rand_fd", n_fd, 2);
      chk("rand_be", n_be, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
